// File: rtl/fixed_addsub_pipe_pkg.sv
// rtl/fixed_addsub_pipe_pkg.sv - shared types and fixed-point clamp helpers
package fixed_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Largest positive value of a bits-wide two's-complement word, zero-extended to 64 bits.
    function automatic logic [63:0] fx_max(input int bits);
        return (64'd1 << (bits - 1)) - 64'd1;
    endfunction

    // Most negative value of a bits-wide two's-complement word, as its raw bit pattern.
    function automatic logic [63:0] fx_min(input int bits);
        return 64'd1 << (bits - 1);
    endfunction

    // Reduce a (bits+1)-bit extended result to bits: returns {ovf, c}.
    // The two top bits of ext disagree exactly when the true result left the range.
    function automatic logic [64:0] fx_clamp(input logic [64:0] ext, input int bits, input bit saturate);
        logic [6:0]  top_idx;
        logic [63:0] mask;
        logic [63:0] res;
        logic        ovf;
        top_idx = 7'(bits);
        mask    = (bits >= 64) ? '1 : ((64'd1 << bits) - 64'd1);
        ovf     = ext[top_idx] ^ ext[top_idx - 7'd1];
        if (ovf && saturate) begin
            res = ext[top_idx] ? fx_min(bits) : fx_max(bits);
        end else begin
            res = ext[63:0] & mask;
        end
        return {ovf, res};
    endfunction

endpackage

// File: rtl/fixed_addsub_pipe_if.sv
// rtl/fixed_addsub_pipe_if.sv - handshake and data bundle for the add/sub pipeline
interface fixed_addsub_pipe_if #(
    parameter int BITS  = 16,
    parameter int LANES = 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  op;
    logic [LANES*BITS-1:0] a;
    logic [LANES*BITS-1:0] b;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*BITS-1:0] c;
    logic [LANES-1:0]      ovf;
    logic [LANES-1:0]      ovf_sticky;
    logic                  clr_ovf;

    modport master (
        output in_valid, op, a, b, out_ready, clr_ovf,
        input  in_ready, out_valid, c, ovf, ovf_sticky
    );

    modport slave (
        input  in_valid, op, a, b, out_ready, clr_ovf,
        output in_ready, out_valid, c, ovf, ovf_sticky
    );
endinterface

// File: rtl/fixed_addsub_pipe_lane.sv
// rtl/fixed_addsub_pipe_lane.sv - one lane: extended add/sub and overflow clamp
module fixed_addsub_lane
    import fixed_pkg::*;
#(
    parameter int BITS     = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  op_e             op,
    output logic [BITS:0]   ext,
    input  logic [BITS:0]   ext_q,
    output logic [BITS-1:0] c,
    output logic            ovf
);
    logic [BITS:0] a_x;
    logic [BITS:0] b_x;
    logic [BITS:0] b_sel;
    logic [64:0]   clamp_res;

    // Subtract as a + ~b + 1 in BITS+1 bits so a - min never needs a BITS-wide negation.
    always_comb begin
        a_x   = {a[BITS-1], a};
        b_x   = {b[BITS-1], b};
        b_sel = (op == OP_SUB) ? ~b_x : b_x;
        ext   = a_x + b_sel + {{BITS{1'b0}}, (op == OP_SUB)};
    end

    // Clamp or wrap the registered extended result coming out of the first stage.
    always_comb begin
        clamp_res = fx_clamp(65'(ext_q), BITS, SATURATE);
        c         = clamp_res[BITS-1:0];
        ovf       = clamp_res[64];
    end

    generate
        if (BITS < 64) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^clamp_res[63:BITS];
        end
    endgenerate
endmodule

// File: rtl/fixed_addsub_pipe.sv
// rtl/fixed_addsub_pipe.sv - multi-lane 2-stage fixed-point add/sub with backpressure
module fixed_addsub_pipe
    import fixed_pkg::*;
#(
    parameter int BITS      = 16,
    parameter int FRAC_BITS = 8,
    parameter int LANES     = 1,
    parameter bit SATURATE  = 1'b1
) (
    input logic                clk,
    input logic                rst,
    fixed_addsub_pipe_if.slave bus
);
    localparam int EXT = BITS + 1;

    generate
        if (BITS < 4 || BITS > 64) begin : g_bad_bits
            $error("fixed_addsub_pipe: BITS must be 4..64");
        end
        if (FRAC_BITS < 0 || FRAC_BITS >= BITS) begin : g_bad_frac
            $error("fixed_addsub_pipe: FRAC_BITS must be below BITS");
        end
        if (LANES < 1 || LANES > 16) begin : g_bad_lanes
            $error("fixed_addsub_pipe: LANES must be 1..16");
        end
    endgenerate

    logic                  adv1;
    logic                  adv2;
    logic                  s1_valid;
    op_e                   s1_op;
    logic [LANES*EXT-1:0]  s1_ext;
    logic [LANES*EXT-1:0]  ext_next;
    logic [LANES*BITS-1:0] c_next;
    logic [LANES-1:0]      ovf_next;
    logic                  out_valid_q;
    logic [LANES*BITS-1:0] c_q;
    logic [LANES-1:0]      ovf_q;
    logic [LANES-1:0]      sticky_q;

    // The op of the S1 beat is kept for debug visibility; the clamp does not need it.
    logic unused_s1_op;
    assign unused_s1_op = s1_op;

    // Each stage moves when the one after it has room; a full pipe stalls on out_ready alone.
    always_comb begin
        adv2 = !out_valid_q || bus.out_ready;
        adv1 = !s1_valid || adv2;
    end

    assign bus.in_ready   = adv1;
    assign bus.out_valid  = out_valid_q;
    assign bus.c          = c_q;
    assign bus.ovf        = ovf_q;
    assign bus.ovf_sticky = sticky_q;

    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            fixed_addsub_lane #(
                .BITS     (BITS),
                .SATURATE (SATURATE)
            ) u_lane (
                .a     (bus.a[i*BITS +: BITS]),
                .b     (bus.b[i*BITS +: BITS]),
                .op    (op_e'(bus.op)),
                .ext   (ext_next[i*EXT +: EXT]),
                .ext_q (s1_ext[i*EXT +: EXT]),
                .c     (c_next[i*BITS +: BITS]),
                .ovf   (ovf_next[i])
            );
        end
    endgenerate

    // Stage 1: capture the extended sums of an accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_ext   <= '0;
        end else if (adv1) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_op  <= op_e'(bus.op);
                s1_ext <= ext_next;
            end
        end
    end

    // Stage 2: capture clamped results; held while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            c_q         <= '0;
            ovf_q       <= '0;
        end else if (adv2) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                c_q   <= c_next;
                ovf_q <= ovf_next;
            end
        end
    end

    // Sticky overflow collects ovf on each output transfer; a clear wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
        end else if (bus.clr_ovf) begin
            sticky_q <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            sticky_q <= sticky_q | ovf_q;
        end
    end
endmodule

// File: tb/tb_fixed_addsub_pipe.sv
// tb/tb_fixed_addsub_pipe.sv - directed self-checking bench for fixed_addsub_pipe
module tb_fixed_addsub_pipe;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fixed_addsub_pipe_if #(.BITS(16), .LANES(4)) bus4 ();
    fixed_addsub_pipe_if #(.BITS(16), .LANES(1)) busw ();

    fixed_addsub_pipe #(.BITS(16), .FRAC_BITS(8), .LANES(4), .SATURATE(1'b1)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    fixed_addsub_pipe #(.BITS(16), .FRAC_BITS(8), .LANES(1), .SATURATE(1'b0)) dutw (
        .clk (clk),
        .rst (rst),
        .bus (busw.slave)
    );

    // The wrapping unit mirrors lane 0 of the saturating unit beat for beat.
    assign busw.in_valid  = bus4.in_valid;
    assign busw.op        = bus4.op;
    assign busw.a         = bus4.a[15:0];
    assign busw.b         = bus4.b[15:0];
    assign busw.out_ready = bus4.out_ready;
    assign busw.clr_ovf   = bus4.clr_ovf;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat into an empty pipe and wait (bounded) for out_valid.
    task automatic run4(input logic op, input logic [63:0] a, input logic [63:0] b, output int lat);
        bus4.op       = op;
        bus4.a        = a;
        bus4.b        = b;
        bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        lat = 1;
        while (!bus4.out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    function automatic logic [15:0] va(input int k, input int l);
        case (l)
            0:       return 16'(k * 256);
            1:       return 16'(65280 - k * 16);
            2:       return 16'(32768 + k);
            default: return 16'(28672 + k * 512);
        endcase
    endfunction

    function automatic logic [15:0] vb(input int l);
        case (l)
            0:       return 16'h0080;
            1:       return 16'h0100;
            2:       return 16'h0004;
            default: return 16'h0C00;
        endcase
    endfunction

    // Integer reference: exact signed result, then saturate to 16 bits.
    task automatic ref_lane(input logic [15:0] a, input logic [15:0] b, input logic op,
                            output logic [15:0] c, output logic o);
        int r;
        r = op ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        o = (r > 32767) || (r < -32768);
        if (r > 32767)       c = 16'h7FFF;
        else if (r < -32768) c = 16'h8000;
        else                 c = 16'(r);
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.op        = 1'b0;
        bus4.a         = '0;
        bus4.b         = '0;
        bus4.out_ready = 1'b1;
        bus4.clr_ovf   = 1'b0;
        tick();
        tick();
        n_tests++;
        if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus4.out_valid); end
        n_tests++;
        if (bus4.c !== 64'h0) begin n_fail++; $display("FAIL reset_c: got %h want 0", bus4.c); end
        n_tests++;
        if (bus4.ovf !== 4'h0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0000", bus4.ovf); end
        n_tests++;
        if (bus4.ovf_sticky !== 4'h0) begin n_fail++; $display("FAIL reset_sticky: got %b want 0000", bus4.ovf_sticky); end
        n_tests++;
        if (busw.out_valid !== 1'b0 || busw.c !== 16'h0) begin
            n_fail++; $display("FAIL reset_wrap: got valid=%b c=%h want 0/0000", busw.out_valid, busw.c);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (bus4.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus4.in_ready); end
    endtask

    task automatic test_add();
        int lat;
        bus4.out_ready = 1'b1;
        run4(1'b0, 64'h0180, 64'h0240, lat);
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d want 2", lat); end
        n_tests++;
        if (bus4.c !== 64'h03C0) begin n_fail++; $display("FAIL add_c: got %h want 00000000000003c0", bus4.c); end
        n_tests++;
        if (bus4.ovf !== 4'h0) begin n_fail++; $display("FAIL add_ovf: got %b want 0000", bus4.ovf); end
        n_tests++;
        if (busw.c !== 16'h03C0) begin n_fail++; $display("FAIL add_wrap_c: got %h want 03c0", busw.c); end
        tick();
    endtask

    task automatic test_sat_overflow();
        int lat;
        bus4.out_ready = 1'b1;
        run4(1'b0, 64'h7F00, 64'h0200, lat);
        n_tests++;
        if (bus4.c !== 64'h7FFF) begin n_fail++; $display("FAIL sat_c: got %h want 0000000000007fff", bus4.c); end
        n_tests++;
        if (bus4.ovf !== 4'b0001) begin n_fail++; $display("FAIL sat_ovf: got %b want 0001", bus4.ovf); end
        n_tests++;
        if (busw.c !== 16'h8100 || busw.ovf !== 1'b1) begin
            n_fail++; $display("FAIL wrap_add: got c=%h ovf=%b want 8100/1", busw.c, busw.ovf);
        end
        tick();
        n_tests++;
        if (bus4.ovf_sticky !== 4'b0001) begin n_fail++; $display("FAIL sat_sticky_set: got %b want 0001", bus4.ovf_sticky); end
        n_tests++;
        if (busw.ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL wrap_sticky_set: got %b want 1", busw.ovf_sticky); end
        bus4.clr_ovf = 1'b1;
        tick();
        bus4.clr_ovf = 1'b0;
        n_tests++;
        if (bus4.ovf_sticky !== 4'b0000) begin n_fail++; $display("FAIL sat_sticky_clr: got %b want 0000", bus4.ovf_sticky); end
        n_tests++;
        if (busw.ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL wrap_sticky_clr: got %b want 0", busw.ovf_sticky); end
    endtask

    task automatic test_sub_boundary();
        int lat;
        bus4.out_ready = 1'b1;
        run4(1'b1, {16'h0001, 16'h8000, 16'hFF00, 16'h0000},
                   {16'h0003, 16'h8000, 16'h7FFF, 16'h8000}, lat);
        n_tests++;
        if (bus4.c !== {16'hFFFE, 16'h0000, 16'h8000, 16'h7FFF}) begin
            n_fail++; $display("FAIL sub_c: got %h want fffe000080007fff", bus4.c);
        end
        n_tests++;
        if (bus4.ovf !== 4'b0011) begin n_fail++; $display("FAIL sub_ovf: got %b want 0011", bus4.ovf); end
        n_tests++;
        if (busw.c !== 16'h8000 || busw.ovf !== 1'b1) begin
            n_fail++; $display("FAIL wrap_sub_min: got c=%h ovf=%b want 8000/1", busw.c, busw.ovf);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_c   [10];
        logic [3:0]  exp_ovf [10];
        logic [63:0] held_c;
        logic [3:0]  held_ovf;
        logic [15:0] lc;
        logic        lo;
        logic [3:0]  pat;
        logic        stalled;
        logic        in_fire;
        logic        out_fire;
        int          sent;
        int          got;
        int          cyc;
        pat      = 4'b1001;
        stalled  = 1'b0;
        held_c   = '0;
        held_ovf = '0;
        sent     = 0;
        got      = 0;
        cyc      = 0;
        for (int k = 0; k < 10; k++) begin
            for (int l = 0; l < 4; l++) begin
                ref_lane(va(k, l), vb(l), k[0], lc, lo);
                exp_c[k][l*16 +: 16] = lc;
                exp_ovf[k][l]        = lo;
            end
        end
        while (got < 10 && cyc < 200) begin
            bus4.out_ready = (cyc < 16) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
            bus4.in_valid  = (sent < 10);
            if (sent < 10) begin
                bus4.op = sent[0];
                for (int l = 0; l < 4; l++) begin
                    bus4.a[l*16 +: 16] = va(sent, l);
                    bus4.b[l*16 +: 16] = vb(l);
                end
            end
            #1;
            if (stalled) begin
                n_tests++;
                if (bus4.out_valid !== 1'b1 || bus4.c !== held_c || bus4.ovf !== held_ovf) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b c=%h ovf=%b want 1 c=%h ovf=%b",
                             bus4.out_valid, bus4.c, bus4.ovf, held_c, held_ovf);
                end
            end
            n_tests++;
            if (bus4.in_ready !== !((sent - got) == 2 && !bus4.out_ready)) begin
                n_fail++;
                $display("FAIL stream_in_ready: got %b want %b (in flight %0d, out_ready %b)",
                         bus4.in_ready, !((sent - got) == 2 && !bus4.out_ready), sent - got, bus4.out_ready);
            end
            in_fire  = bus4.in_valid && bus4.in_ready;
            out_fire = bus4.out_valid && bus4.out_ready;
            if (out_fire) begin
                n_tests++;
                if (bus4.c !== exp_c[got] || bus4.ovf !== exp_ovf[got]) begin
                    n_fail++;
                    $display("FAIL stream_beat%0d: got c=%h ovf=%b want c=%h ovf=%b",
                             got, bus4.c, bus4.ovf, exp_c[got], exp_ovf[got]);
                end
                got++;
            end
            stalled  = bus4.out_valid && !bus4.out_ready;
            held_c   = bus4.c;
            held_ovf = bus4.ovf;
            if (in_fire) sent++;
            tick();
            cyc++;
        end
        n_tests++;
        if (got !== 10) begin n_fail++; $display("FAIL stream_count: got %0d beats want 10", got); end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            n_tests++;
            if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_extra_beat: got out_valid=%b want 0", bus4.out_valid); end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        int lat;
        bus4.out_ready = 1'b1;
        run4(1'b0, 64'h7F00, 64'h0200, lat);
        tick();
        n_tests++;
        if (bus4.ovf_sticky[0] !== 1'b1) begin n_fail++; $display("FAIL mid_sticky_pre: got %b want 1", bus4.ovf_sticky[0]); end
        bus4.out_ready = 1'b0;
        bus4.in_valid  = 1'b1;
        bus4.a         = 64'h0100;
        bus4.b         = 64'h0100;
        tick();
        bus4.a = 64'h0300;
        tick();
        bus4.in_valid = 1'b0;
        n_tests++;
        if (bus4.in_ready !== 1'b0 || bus4.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_full: got in_ready=%b out_valid=%b want 0/1", bus4.in_ready, bus4.out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (bus4.out_valid !== 1'b0 || bus4.c !== 64'h0 || bus4.ovf !== 4'h0) begin
            n_fail++; $display("FAIL mid_reset_out: got v=%b c=%h ovf=%b want 0/0/0", bus4.out_valid, bus4.c, bus4.ovf);
        end
        n_tests++;
        if (bus4.ovf_sticky !== 4'h0) begin n_fail++; $display("FAIL mid_reset_sticky: got %b want 0000", bus4.ovf_sticky); end
        n_tests++;
        if (bus4.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_in_ready: got %b want 1", bus4.in_ready); end
        bus4.out_ready = 1'b1;
        run4(1'b0, 64'h0010, 64'h0020, lat);
        n_tests++;
        if (lat !== 2 || bus4.c !== 64'h0030) begin
            n_fail++; $display("FAIL mid_after_reset: got lat=%0d c=%h want 2/0000000000000030", lat, bus4.c);
        end
        tick();
        for (int j = 0; j < 2; j++) begin
            n_tests++;
            if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ghost_beat: got out_valid=%b want 0", bus4.out_valid); end
            tick();
        end
    endtask

    task automatic test_clr_same_cycle();
        int lat;
        bus4.out_ready = 1'b1;
        run4(1'b0, {16'h0, 16'h0, 16'h7FFF, 16'h0}, {16'h0, 16'h0, 16'h0001, 16'h0}, lat);
        tick();
        n_tests++;
        if (bus4.ovf_sticky !== 4'b0010) begin n_fail++; $display("FAIL clr_sticky_pre: got %b want 0010", bus4.ovf_sticky); end
        run4(1'b0, 64'h7F00, 64'h0200, lat);
        n_tests++;
        if (bus4.ovf !== 4'b0001 || bus4.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL clr_beat_ovf: got v=%b ovf=%b want 1/0001", bus4.out_valid, bus4.ovf);
        end
        bus4.clr_ovf = 1'b1;
        tick();
        bus4.clr_ovf = 1'b0;
        n_tests++;
        if (bus4.ovf_sticky !== 4'b0000) begin n_fail++; $display("FAIL clr_priority: got %b want 0000", bus4.ovf_sticky); end
        n_tests++;
        if (busw.ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_priority_wrap: got %b want 0", busw.ovf_sticky); end
        n_tests++;
        if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_beat_taken: got out_valid=%b want 0", bus4.out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sat_overflow();
        test_sub_boundary();
        test_back_to_back();
        test_reset_midflight();
        test_clr_same_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_addsub_pipe.md
Name: fixed_addsub_pipe

Overview:
- Parametrised, multi-lane, 2-stage pipelined fixed-point add/subtract unit with a per-transaction op select.
- Overflow handling is selectable: saturate or wrap. Overflow is flagged per lane and accumulated in a sticky status register.
- Full valid/ready backpressure on both input and output.
- Drop-in arithmetic primitive for the fixed-point datapaths (filters, accumulators) in place of separate add and subtract instances.

Parameters:
- BITS, 16, total two's-complement word width per lane (sign included); legal range 4..64.
- FRAC_BITS, 8, fractional bits; informational only, since arithmetic is binary-point agnostic. Must be < BITS.
- LANES, 1, number of independent lanes sharing one handshake; 1..16.
- SATURATE, 1, 1 = clamp to max/min on overflow, 0 = wrap modulo 2^BITS.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  unit can accept input this cycle
- op  in  1  0 = add (a+b), 1 = subtract (a-b); applies to all lanes
- a  in  LANES*BITS  lane i at [i*BITS +: BITS]
- b  in  LANES*BITS  same packing as a
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- c  out  LANES*BITS  results, same packing
- ovf  out  LANES  per-lane overflow for the current output beat
- ovf_sticky  out  LANES  OR of all ovf beats since reset or last clear
- clr_ovf  in  1  clears ovf_sticky (synchronous)

Behaviour:
- Reset: all outputs are 0 on the clock after rst is sampled high, i.e. out_valid=0, c=0, ovf=0, ovf_sticky=0, both stage valids=0. in_ready reads 1 once rst deasserts. An in-flight beat during reset is dropped, with no partial output.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - c, ovf and out_valid hold stable while out_valid && !out_ready.
- Pipeline:
  - S1 registers the sign-extended (BITS+1)-bit result a+b or a+~b+1, plus op.
  - S2 registers the clamped or wrapped c and ovf.
  - Latency is exactly 2 cycles from input transfer to out_valid with no stall. Throughput is 1 beat/cycle.
- Stall logic: adv2 = !out_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1 (combinational from out_ready; no bubble insertion).
- Arithmetic per lane, with ext = result in BITS+1 bits:
  - Overflow iff ext[BITS] != ext[BITS-1].
  - SATURATE=1: positive overflow gives 0 followed by all-ones (max), negative overflow gives 1 followed by all-zeros (min).
  - SATURATE=0: c = ext[BITS-1:0].
  - ovf is set on overflow regardless of mode.
- Subtract of min: a - min is computed exactly in the extended width. It is never negated in BITS width, so it is correct at the boundary.
- ovf_sticky:
  - Updates only on an output transfer: sticky |= ovf.
  - clr_ovf has priority over the set in the same cycle.
  - Simultaneous clear and overflow beat: sticky = 0 and the beat's ovf is lost from sticky. The beat's own ovf port is still correct.
- Lanes are fully independent; no carry between lanes.

Decomposition:
- Package fixed_pkg:
  - op_e enum (OP_ADD=0, OP_SUB=1)
  - functions fx_max(BITS) and fx_min(BITS)
  - function fx_clamp(ext, BITS, SATURATE), which returns {ovf, c}
- Sub-module fixed_addsub_lane: combinational per-lane extended add/sub plus clamp, instantiated LANES times via generate.
- The top level owns only the handshake, pipeline registers and the sticky register.

Test Plan:
- BITS=16, FRAC=8, op=0: a=0x0180 (1.5), b=0x0240 (2.25) -> c=0x03C0, ovf=0, out_valid exactly 2 cycles after accept.
- SATURATE=1, op=0: a=0x7F00, b=0x0200 -> c=0x7FFF, ovf=1, ovf_sticky=1. Then clr_ovf pulse -> ovf_sticky=0.
- op=1: a=0x0000, b=0x8000 -> SATURATE=1 gives c=0x7FFF, ovf=1; SATURATE=0 gives c=0x8000, ovf=1. Also a=0xFF00, b=0x7FFF (SAT) -> c=0x8000, ovf=1.
- LANES=4, streaming 10 back-to-back beats with out_ready toggling 1,0,0,1 randomly -> all 10 results in order, none lost or duplicated, c stable during stall, in_ready=0 only when both stages full and out_ready=0.
- Assert rst for one cycle with both stages full -> next cycle out_valid=0, ovf_sticky=0, c=0; a new beat issued after reset emerges alone at latency 2.
- Same-cycle clr_ovf and an overflowing output transfer -> ovf=1 on that beat, ovf_sticky=0 afterwards.
